// File: rtl/shift_reg_piso_tx.sv
// Parallel-in/serial-out transmit shift register.
// Takes one word over a valid/ready handshake and presents it one bit per shift_en
// strobe on data_out, so a receiver clocked by the same shift_en rebuilds the word.
module shift_reg_piso_tx #(
  parameter int unsigned data_width = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [data_width-1:0]         load_data,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic                          shift_en,
  input  logic                          abort,
  output logic                          data_out,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(data_width):0]   bit_cnt
);

  localparam int unsigned CntW = $clog2(data_width) + 1;

  typedef enum logic {StIdle, StShift} state_e;

  state_e                state_q;
  logic [data_width-1:0] shreg_q;
  logic [data_width-1:0] shreg_shifted;
  logic [CntW-1:0]       cnt_q;
  logic                  data_out_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  first_bit;
  logic                  next_bit;

  // Shift toward the output end; the bit now at the output end is the next to send.
  always_comb begin
    shreg_shifted = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
    next_bit      = MSB_FIRST ? shreg_shifted[data_width-1] : shreg_shifted[0];
    first_bit     = MSB_FIRST ? load_data[data_width-1] : load_data[0];
  end

  // Frame sequencer; every output except load_ready is registered here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      cnt_q      <= '0;
      data_out_q <= IDLE_LEVEL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        // Abort wins over shift_en and load_valid; the partial frame gets no done.
        state_q    <= StIdle;
        cnt_q      <= '0;
        data_out_q <= IDLE_LEVEL;
        busy_q     <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (load_valid) begin
              shreg_q    <= load_data;
              cnt_q      <= '0;
              data_out_q <= first_bit;
              busy_q     <= 1'b1;
              state_q    <= StShift;
            end
          end
          StShift: begin
            if (shift_en) begin
              if (cnt_q == CntW'(data_width - 1)) begin
                // Last bit consumed; count stays at data_width until the next load.
                cnt_q      <= CntW'(data_width);
                data_out_q <= IDLE_LEVEL;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                state_q    <= StIdle;
              end else begin
                cnt_q      <= cnt_q + CntW'(1);
                shreg_q    <= shreg_shifted;
                data_out_q <= next_bit;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign load_ready = (state_q == StIdle);
  assign data_out   = data_out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// Bench for shift_reg_piso_tx: three instances (MSB-first, LSB-first, 1-bit frame)
// share one stimulus stream; a word-level model predicts every output each cycle.
module tb_shift_reg_piso_tx;

  logic       clk;
  logic       rstn;
  logic [7:0] load_data;
  logic       load_valid;
  logic       shift_en;
  logic       abort;

  logic       dout  [3];
  logic       busy  [3];
  logic       done  [3];
  logic       lr    [3];
  logic [3:0] cnt   [3];
  logic [3:0] cnt0;
  logic [3:0] cnt1;
  logic [0:0] cnt2;

  int tests;
  int errors;

  shift_reg_piso_tx #(.data_width(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .rstn(rstn), .load_data(load_data), .load_valid(load_valid),
    .load_ready(lr[0]), .shift_en(shift_en), .abort(abort), .data_out(dout[0]),
    .busy(busy[0]), .done(done[0]), .bit_cnt(cnt0)
  );

  shift_reg_piso_tx #(.data_width(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .rstn(rstn), .load_data(load_data), .load_valid(load_valid),
    .load_ready(lr[1]), .shift_en(shift_en), .abort(abort), .data_out(dout[1]),
    .busy(busy[1]), .done(done[1]), .bit_cnt(cnt1)
  );

  shift_reg_piso_tx #(.data_width(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_w1 (
    .clk(clk), .rstn(rstn), .load_data(load_data[0:0]), .load_valid(load_valid),
    .load_ready(lr[2]), .shift_en(shift_en), .abort(abort), .data_out(dout[2]),
    .busy(busy[2]), .done(done[2]), .bit_cnt(cnt2)
  );

  assign cnt[0] = cnt0;
  assign cnt[1] = cnt1;
  assign cnt[2] = {3'b000, cnt2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: a frame is (word, bits consumed); the line shows word bit k.
  int         m_w   [3] = '{8, 8, 1};
  bit         m_msb [3] = '{1'b1, 1'b0, 1'b1};
  logic       m_act [3];
  logic [7:0] m_word[3];
  int         m_k   [3];
  logic       m_done[3];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 3; i++) begin
        m_act[i]  <= 1'b0;
        m_word[i] <= 8'h00;
        m_k[i]    <= 0;
        m_done[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_done[i] <= 1'b0;
        if (abort) begin
          m_act[i] <= 1'b0;
          m_k[i]   <= 0;
        end else if (!m_act[i]) begin
          if (load_valid) begin
            m_act[i]  <= 1'b1;
            m_word[i] <= load_data;
            m_k[i]    <= 0;
          end
        end else if (shift_en) begin
          m_k[i] <= m_k[i] + 1;
          if (m_k[i] + 1 == m_w[i]) begin
            m_act[i]  <= 1'b0;
            m_done[i] <= 1'b1;
          end
        end
      end
    end
  end

  function automatic logic exp_bit(input int i);
    int idx;
    idx = m_msb[i] ? (m_w[i] - 1 - m_k[i]) : m_k[i];
    return m_act[i] ? m_word[i][idx] : 1'b0;
  endfunction

  // Receivers sharing shift_en: MSB-first fills from the right, LSB-first from the left.
  logic [7:0] rx0;
  logic [7:0] rx1;
  int         dcnt0;

  always @(posedge clk) begin
    if (shift_en) begin
      rx0 <= {rx0[6:0], dout[0]};
      rx1 <= {dout[1], rx1[7:1]};
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("data_out%0d", i), 32'(dout[i]), 32'(exp_bit(i)));
        chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_act[i]));
        chk($sformatf("done%0d", i), 32'(done[i]), 32'(m_done[i]));
        chk($sformatf("load_ready%0d", i), 32'(lr[i]), 32'(!m_act[i]));
        chk($sformatf("bit_cnt%0d", i), 32'(cnt[i]), 32'(m_k[i]));
      end
      if (done[0]) dcnt0++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] w);
    load_valid = 1'b1;
    load_data  = w;
    cyc();
    load_valid = 1'b0;
  endtask

  task automatic shift_n(input int n);
    shift_en = 1'b1;
    repeat (n) cyc();
    shift_en = 1'b0;
  endtask

  bit seq_a5 [8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  bit pat3   [15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                      1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int d0;
    int low;
    tests      = 0;
    errors     = 0;
    dcnt0      = 0;
    rx0        = 8'h00;
    rx1        = 8'h00;
    load_data  = 8'h00;
    load_valid = 1'b0;
    shift_en   = 1'b0;
    abort      = 1'b0;
    rstn       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data_out", 32'(dout[0]), 32'd0);
    chk("reset_load_ready", 32'(lr[0]), 32'd1);
    rstn = 1'b1;
    cyc();

    // Reset mid-frame after three bits: immediate return to idle, no done.
    d0 = dcnt0;
    load(8'hC3);
    shift_n(3);
    chk("pre_reset_busy", 32'(busy[0]), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("async_data_out", 32'(dout[0]), 32'd0);
    chk("async_busy", 32'(busy[0]), 32'd0);
    chk("async_load_ready", 32'(lr[0]), 32'd1);
    chk("async_bit_cnt", 32'(cnt[0]), 32'd0);
    cyc();
    rstn = 1'b1;
    cyc();
    chk("reset_no_done", 32'(dcnt0 - d0), 32'd0);

    // 8'hA5 with shift_en held high.
    d0 = dcnt0;
    load(8'hA5);
    shift_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("a5_bit%0d", i), 32'(dout[0]), 32'(seq_a5[i]));
      cyc();
    end
    shift_en = 1'b0;
    chk("a5_done", 32'(done[0]), 32'd1);
    chk("a5_rx", 32'(rx0), 32'hA5);
    chk("a5_bit_cnt", 32'(cnt[0]), 32'd8);
    cyc();
    chk("a5_done_clear", 32'(done[0]), 32'd0);
    chk("a5_done_count", 32'(dcnt0 - d0), 32'd1);

    // 8'h3C with irregular shift_en gaps.
    d0 = dcnt0;
    load(8'h3C);
    for (int i = 0; i < 15; i++) begin
      shift_en = pat3[i];
      cyc();
    end
    shift_en = 1'b0;
    chk("3c_rx", 32'(rx0), 32'h3C);
    shift_n(2);
    cyc();
    chk("3c_done_once", 32'(dcnt0 - d0), 32'd1);

    // LSB-first instance with 8'h01.
    load(8'h01);
    chk("lsb_first_bit", 32'(dout[1]), 32'd1);
    chk("lsb_cnt_start", 32'(cnt[1]), 32'd0);
    shift_n(1);
    chk("lsb_second_bit", 32'(dout[1]), 32'd0);
    chk("lsb_cnt_one", 32'(cnt[1]), 32'd1);
    shift_n(7);
    chk("lsb_cnt_end", 32'(cnt[1]), 32'd8);
    chk("lsb_rx", 32'(rx1), 32'h01);
    cyc();

    // Back-to-back words with load_valid held high.
    load_valid = 1'b1;
    load_data  = 8'hFF;
    cyc();
    chk("b2b_accept_ff", 32'(lr[0]), 32'd0);
    load_data = 8'h00;
    shift_en  = 1'b1;
    low = 0;
    while (!lr[0] && low < 20) begin
      cyc();
      low++;
    end
    chk("b2b_low_edges", 32'(low), 32'd8);
    chk("b2b_done_ff", 32'(done[0]), 32'd1);
    chk("b2b_rx_ff", 32'(rx0), 32'hFF);
    cyc();
    load_valid = 1'b0;
    chk("b2b_accept_00", 32'(busy[0]), 32'd1);
    repeat (8) cyc();
    shift_en = 1'b0;
    chk("b2b_done_00", 32'(done[0]), 32'd1);
    chk("b2b_rx_00", 32'(rx0), 32'h00);
    cyc();

    // Abort together with shift_en after four bits, then a clean 8'h81 frame.
    d0 = dcnt0;
    load(8'h5A);
    shift_n(4);
    abort    = 1'b1;
    shift_en = 1'b1;
    cyc();
    abort    = 1'b0;
    shift_en = 1'b0;
    chk("abort_bit_cnt", 32'(cnt[0]), 32'd0);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_data_out", 32'(dout[0]), 32'd0);
    chk("abort_load_ready", 32'(lr[0]), 32'd1);
    cyc();
    chk("abort_no_done", 32'(dcnt0 - d0), 32'd0);
    load(8'h81);
    shift_n(8);
    chk("post_abort_rx", 32'(rx0), 32'h81);
    chk("post_abort_done", 32'(done[0]), 32'd1);
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "timeout");
  end

endmodule
